// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path: FSM state type,
// opcode values and datapath select encodings. Also used by the ALU decoder.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_AUIPC,
    S_ALUWB,
    S_JAL,
    S_JALR_A,
    S_JALR_B,
    S_BEQ,
    S_LUI,
    S_ILLEGAL,
    S_EXECM,
    S_MDUWB
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Writeback result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // States that stall on an external completion input and are timed
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE) || (s == S_EXECM);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-state watchdog. Counts cycles while en is high; expired is raised
// combinationally during the MEM_TIMEOUT-th counted cycle so the FSM can abort
// in that same cycle. MEM_TIMEOUT = 0 disables expiry.
module mc_wait_timer #(
  parameter int TMR_W       = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [TMR_W-1:0] MAXV  = {TMR_W{1'b1}};

  logic [TMR_W-1:0] cnt;

  // Wait-cycle counter; saturates so a disabled timeout never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAXV)) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RISC-V main control FSM. Moore-style datapath controls with
// mem_ready-qualified fetch/store strobes, variable-latency memory handshake,
// wait-state timeout (bus_err), JALR/AUIPC sequencing and illegal-opcode trap.
// Optional feature macro: MC_FSM_MULDIV_EN adds the iterative mul/div path
// (EXECM/MDUWB states, mdu_start/mdu_sel); without it funct7 and mdu_done are
// ignored and mdu_start/mdu_sel stay 0.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       mdu_done,
  output logic       Branch,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       mem_req,
  output logic       mdu_start,
  output logic       mdu_sel,
  output logic       illegal,
  output logic       bus_err
);

  state_t state, state_nx;
  logic   done;
  logic   timeout;
  logic   tmr_en;
  logic   tmr_clr;

`ifdef MC_FSM_MULDIV_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  logic mdu_launched;

  // Completion input of the current wait state
  assign done = (state == S_EXECM) ? mdu_done : mem_ready;

  // Remembers that EXECM has already issued its launch pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdu_launched <= 1'b0;
    end else begin
      mdu_launched <= (state == S_EXECM);
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{funct7, mdu_done};
  assign done = mem_ready;
`endif

  // Timer counts stalled wait cycles and restarts on any state change or abort
  assign tmr_en  = is_wait_state(state) && !done;
  assign tmr_clr = (state_nx != state) || timeout;

  mc_wait_timer #(
    .TMR_W      (TMR_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(timeout)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and datapath controls decoded from the current state
  always_comb begin
    state_nx  = state;
    Branch    = 1'b0;
    PCUpdate  = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    mem_req   = 1'b0;
    mdu_start = 1'b0;
    mdu_sel   = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        // A timeout here simply restarts the fetch
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
`ifdef MC_FSM_MULDIV_EN
          OP_RTYPE:     state_nx = (funct7 == F7_MULDIV) ? S_EXECM : S_EXECR;
`else
          OP_RTYPE:     state_nx = S_EXECR;
`endif
          OP_ITYPE:     state_nx = S_EXECI;
          OP_BEQ:       state_nx = S_BEQ;
          OP_JAL:       state_nx = S_JAL;
          OP_JALR:      state_nx = S_JALR_A;
          OP_LUI:       state_nx = S_LUI;
          OP_AUIPC:     state_nx = S_AUIPC;
          default:      state_nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_IMM;
        state_nx = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready)    state_nx = S_MEMWB;
        else if (timeout) state_nx = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
        if (mem_ready || timeout) state_nx = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_nx  = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_RS2;
        ALUOp    = ALUOP_FUNCT;
        state_nx = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_IMM;
        ALUOp    = ALUOP_FUNCT;
        state_nx = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_IMM;
        state_nx = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_nx  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCUpdate  = 1'b1;
        state_nx  = S_ALUWB;
      end
      S_JALR_A: begin
        // Jump target into ALUOut
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_IMM;
        state_nx = S_JALR_B;
      end
      S_JALR_B: begin
        // PC <- target while ALUOut picks up the link value OldPC+4
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCUpdate  = 1'b1;
        state_nx  = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        Branch    = 1'b1;
        state_nx  = S_FETCH;
      end
      S_LUI: begin
        ResultSrc = RES_IMMEXT;
        RegWrite  = 1'b1;
        state_nx  = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal  = 1'b1;
        state_nx = S_FETCH;
      end
`ifdef MC_FSM_MULDIV_EN
      S_EXECM: begin
        mdu_start = !mdu_launched;
        if (mdu_done)     state_nx = S_MDUWB;
        else if (timeout) state_nx = S_FETCH;
      end
      S_MDUWB: begin
        mdu_sel  = 1'b1;
        RegWrite = 1'b1;
        state_nx = S_FETCH;
      end
`endif
      default: state_nx = S_FETCH;
    endcase

    bus_err = timeout;

    // No strobe or bus request may escape while reset is held
    if (reset) begin
      Branch    = 1'b0;
      PCUpdate  = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      mem_req   = 1'b0;
      mdu_start = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm. A step-sequence model (instruction ->
// list of steps, each step -> output table) is compared against the DUT on
// every negedge; directed scenarios add hand-computed literal checks.
module tb_mc_ctrl_fsm;

`ifdef MC_FSM_MULDIV_EN
  localparam int TMO = 8;
  localparam int TW  = 4;
`else
  localparam int TMO = 4;
  localparam int TW  = 3;
`endif

  // Bit positions inside the packed output vector
  localparam int B_BR = 18, B_PCU = 17, B_RW = 16, B_MW = 15, B_IRW = 14, B_ADR = 13;
  localparam int B_REQ = 4, B_MST = 3, B_MSEL = 2, B_ILL = 1, B_BERR = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic [6:0] funct7 = 7'b0;
  logic mem_ready = 1'b0;
  logic mdu_done = 1'b0;
  logic Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic mem_req, mdu_start, mdu_sel, illegal, bus_err;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .TMR_W(TW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct7(funct7),
    .mem_ready(mem_ready), .mdu_done(mdu_done),
    .Branch(Branch), .PCUpdate(PCUpdate), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .mem_req(mem_req), .mdu_start(mdu_start),
    .mdu_sel(mdu_sel), .illegal(illegal), .bus_err(bus_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [18:0] tr [0:63];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] outs_now();
    return {Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
            ALUSrcA, ALUSrcB, ALUOp, mem_req, mdu_start, mdu_sel, illegal, bus_err};
  endfunction

  // ---------------- behavioural model ----------------
  string m_cur = "FETCH";
  string m_rest[$];
  int    m_waits = 0;

  function automatic bit is_wait(input string s);
    return (s == "FETCH") || (s == "MEMREAD") || (s == "MEMWRITE") || (s == "EXECM");
  endfunction

  function automatic logic [18:0] model_outs(input string s, input bit rdy, input bit mdone,
                                             input int waits, input bit rst);
    bit br = 0, pcu = 0, rw = 0, mw = 0, irw = 0, adr = 0;
    bit req = 0, mst = 0, msel = 0, ill = 0, berr = 0, cmpl;
    logic [1:0] rs = 2'd0, a = 2'd0, b = 2'd0, aop = 2'd0;
    case (s)
      "FETCH":    begin req = 1; b = 2; rs = 2; irw = rdy; pcu = rdy; end
      "DECODE":   begin a = 1; b = 1; end
      "MEMADR":   begin a = 2; b = 1; end
      "MEMREAD":  begin req = 1; adr = 1; end
      "MEMWRITE": begin req = 1; adr = 1; mw = rdy; end
      "MEMWB":    begin rs = 1; rw = 1; end
      "EXECR":    begin a = 2; b = 0; aop = 2; end
      "EXECI":    begin a = 2; b = 1; aop = 2; end
      "AUIPC":    begin a = 1; b = 1; end
      "ALUWB":    begin rs = 0; rw = 1; end
      "JAL":      begin a = 1; b = 2; pcu = 1; end
      "JALR_A":   begin a = 2; b = 1; end
      "JALR_B":   begin a = 1; b = 2; pcu = 1; end
      "BEQ":      begin a = 2; b = 0; aop = 1; br = 1; end
      "LUI":      begin rs = 3; rw = 1; end
      "ILLEGAL":  begin ill = 1; end
      "EXECM":    begin mst = (waits == 0); end
      "MDUWB":    begin msel = 1; rw = 1; end
      default:    begin end
    endcase
    cmpl = (s == "EXECM") ? mdone : rdy;
    berr = is_wait(s) && !cmpl && (TMO != 0) && (waits == TMO - 1);
    if (rst) begin
      br = 0; pcu = 0; rw = 0; mw = 0; irw = 0; req = 0; mst = 0; ill = 0; berr = 0;
    end
    return {br, pcu, rw, mw, irw, adr, rs, a, b, aop, req, mst, msel, ill, berr};
  endfunction

  // Model advance: each instruction expands into its step list at decode
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_cur = "FETCH"; m_rest.delete(); m_waits = 0;
    end else if (is_wait(m_cur) && !((m_cur == "EXECM") ? mdu_done : mem_ready)) begin
      if (TMO != 0 && m_waits == TMO - 1) begin
        m_cur = "FETCH"; m_rest.delete(); m_waits = 0;
      end else begin
        m_waits++;
      end
    end else begin
      m_waits = 0;
      if (m_cur == "DECODE") begin
        m_rest.delete();
        case (op)
          7'b0000011: begin m_rest.push_back("MEMADR"); m_rest.push_back("MEMREAD"); m_rest.push_back("MEMWB"); end
          7'b0100011: begin m_rest.push_back("MEMADR"); m_rest.push_back("MEMWRITE"); end
          7'b0110011: begin
`ifdef MC_FSM_MULDIV_EN
            if (funct7 == 7'b0000001) begin m_rest.push_back("EXECM"); m_rest.push_back("MDUWB"); end
            else begin m_rest.push_back("EXECR"); m_rest.push_back("ALUWB"); end
`else
            m_rest.push_back("EXECR"); m_rest.push_back("ALUWB");
`endif
          end
          7'b0010011: begin m_rest.push_back("EXECI"); m_rest.push_back("ALUWB"); end
          7'b1100011: m_rest.push_back("BEQ");
          7'b1101111: begin m_rest.push_back("JAL"); m_rest.push_back("ALUWB"); end
          7'b1100111: begin m_rest.push_back("JALR_A"); m_rest.push_back("JALR_B"); m_rest.push_back("ALUWB"); end
          7'b0110111: m_rest.push_back("LUI");
          7'b0010111: begin m_rest.push_back("AUIPC"); m_rest.push_back("ALUWB"); end
          default:    m_rest.push_back("ILLEGAL");
        endcase
      end
      if (m_cur == "FETCH") m_cur = "DECODE";
      else if (m_rest.size() > 0) m_cur = m_rest.pop_front();
      else m_cur = "FETCH";
    end
  end

  // Per-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      string s;
      int w;
      s = reset ? "FETCH" : m_cur;
      w = reset ? 0 : m_waits;
      check($sformatf("outs@%s", s), int'(outs_now()),
            int'(model_outs(s, mem_ready, mdu_done, w, reset)));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int cnt_bit(input int b, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(tr[i][b]);
    return c;
  endfunction

  task automatic run(input logic [6:0] o, input logic [6:0] f7, input logic [31:0] rdy,
                     input logic [31:0] mdn, input int n);
    for (int i = 0; i < n; i++) begin
      op = o; funct7 = f7; mem_ready = rdy[i]; mdu_done = mdn[i];
      @(negedge clk);
      tr[i] = outs_now();
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1; mdu_done = 1'b0;
    @(negedge clk);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_irwrite", int'(IRWrite), 0);
    @(posedge clk);
    #1;
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    chk_en = 1'b1;

    // lw with 3 stalled fetch cycles and 2 stalled read cycles
    do_reset();
    run(7'b0000011, 7'd0, 32'h0000_0108, 32'h0, 10);
    check("reset_fetch_req", int'(tr[0][B_REQ]), 1);
    check("reset_fetch_srcb", int'(tr[0][8:7]), 2);
    check("reset_fetch_res", int'(tr[0][12:11]), 2);
    check("lw_irwrite_count", cnt_bit(B_IRW, 0, 9), 1);
    check("lw_irwrite_at3", int'(tr[3][B_IRW]), 1);
    // 4 fetch + decode + memadr + 3 memread = 9 cycles before the MEMWB write
    check("lw_memwb_regwrite", int'(tr[9][B_RW]), 1);
    check("lw_memwb_res", int'(tr[9][12:11]), 1);
    check("lw_regwrite_count", cnt_bit(B_RW, 0, 9), 1);
    check("lw_no_buserr", cnt_bit(B_BERR, 0, 9), 0);

    // sw with memory always ready
    do_reset();
    run(7'b0100011, 7'd0, 32'hFFFF_FFFF, 32'h0, 5);
    check("sw_memwrite_count", cnt_bit(B_MW, 0, 4), 1);
    check("sw_memwrite_at3", int'(tr[3][B_MW]), 1);
    check("sw_adrsrc_at3", int'(tr[3][B_ADR]), 1);
    check("sw_back_fetch_req", int'(tr[4][B_REQ]), 1);
    check("sw_back_fetch_adr", int'(tr[4][B_ADR]), 0);
    check("sw_back_fetch_srcb", int'(tr[4][8:7]), 2);

    // jalr sequence
    do_reset();
    run(7'b1100111, 7'd0, 32'h0000_0001, 32'h0, 6);
    check("jalr_a_srca", int'(tr[2][10:9]), 2);
    check("jalr_a_srcb", int'(tr[2][8:7]), 1);
    check("jalr_b_pcupdate", int'(tr[3][B_PCU]), 1);
    check("jalr_b_res", int'(tr[3][12:11]), 0);
    check("jalr_b_srca", int'(tr[3][10:9]), 1);
    check("jalr_aluwb_rw", int'(tr[4][B_RW]), 1);
    check("jalr_pcu_count", cnt_bit(B_PCU, 1, 5), 1);
    check("jalr_back_fetch", int'(tr[5][B_REQ]), 1);

    // unsupported opcode
    do_reset();
    run(7'b1111111, 7'd0, 32'h0000_0001, 32'h0, 4);
    check("ill_pulse_at2", int'(tr[2][B_ILL]), 1);
    check("ill_pulse_count", cnt_bit(B_ILL, 0, 3), 1);
    check("ill_no_writes", cnt_bit(B_RW, 1, 3) + cnt_bit(B_MW, 1, 3) + cnt_bit(B_PCU, 1, 3), 0);
    check("ill_back_fetch", int'(tr[3][B_REQ]), 1);

    // lw whose read never completes: abort on the TMO-th wait cycle
    do_reset();
    run(7'b0000011, 7'd0, 32'h0000_0001, 32'h0, TMO + 4);
    check("tmo_buserr_at", int'(tr[2 + TMO][B_BERR]), 1);
    check("tmo_buserr_count", cnt_bit(B_BERR, 0, TMO + 3), 1);
    check("tmo_no_regwrite", cnt_bit(B_RW, 0, TMO + 3), 0);
    check("tmo_fetch_req", int'(tr[3 + TMO][B_REQ]), 1);
    check("tmo_fetch_adr", int'(tr[3 + TMO][B_ADR]), 0);

    // reset in the middle of a memory read
    do_reset();
    run(7'b0000011, 7'd0, 32'h0000_0001, 32'h0, 4);
    reset = 1'b1;
    #1;
    check("midrst_mem_req", int'(mem_req), 0);
    check("midrst_adrsrc", int'(AdrSrc), 0);
    @(posedge clk);
    #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("midrst_fetch_req", int'(mem_req), 1);
    check("midrst_fetch_bus_err", int'(bus_err), 0);
    @(posedge clk);
    #1;

    // fetch that never completes: abort and restart fetching
    do_reset();
    run(7'b0000011, 7'd0, 32'h0, 32'h0, TMO + 2);
    check("ftmo_buserr_at", int'(tr[TMO - 1][B_BERR]), 1);
    check("ftmo_buserr_count", cnt_bit(B_BERR, 0, TMO + 1), 1);
    check("ftmo_no_irwrite", cnt_bit(B_IRW, 0, TMO + 1), 0);
    check("ftmo_still_fetch", int'(tr[TMO][B_REQ]), 1);

    // remaining instruction classes, memory always ready
    do_reset();
    run(7'b0110111, 7'd0, 32'h0000_0001, 32'h0, 3);
    check("lui_regwrite", int'(tr[2][B_RW]), 1);
    check("lui_res", int'(tr[2][12:11]), 3);
    do_reset();
    run(7'b1100011, 7'd0, 32'h0000_0001, 32'h0, 4);
    check("beq_branch", int'(tr[2][B_BR]), 1);
    check("beq_aluop", int'(tr[2][6:5]), 1);
    do_reset();
    run(7'b0010011, 7'd0, 32'h0000_0001, 32'h0, 5);
    check("execi_aluop", int'(tr[2][6:5]), 2);
    do_reset();
    run(7'b1101111, 7'd0, 32'h0000_0001, 32'h0, 5);
    check("jal_pcupdate", int'(tr[2][B_PCU]), 1);
    do_reset();
    run(7'b0010111, 7'd0, 32'h0000_0001, 32'h0, 5);
    check("auipc_srca", int'(tr[2][10:9]), 1);
    check("auipc_aluwb", int'(tr[3][B_RW]), 1);
    do_reset();
    run(7'b0110011, 7'd0, 32'h0000_0001, 32'h0, 5);
    check("execr_aluop", int'(tr[2][6:5]), 2);

`ifdef MC_FSM_MULDIV_EN
    // mul/div: done arrives on the 6th EXECM cycle
    do_reset();
    run(7'b0110011, 7'b0000001, 32'h0000_0001, 32'h0000_0080, 10);
    check("mdu_start_count", cnt_bit(B_MST, 0, 9), 1);
    check("mdu_start_at2", int'(tr[2][B_MST]), 1);
    check("mduwb_sel", int'(tr[8][B_MSEL]), 1);
    check("mduwb_regwrite", int'(tr[8][B_RW]), 1);
    check("mdu_no_buserr", cnt_bit(B_BERR, 0, 9), 0);
    check("mdu_back_fetch", int'(tr[9][B_REQ]), 1);
`else
    // without the mul/div option funct7 is ignored
    do_reset();
    run(7'b0110011, 7'b0000001, 32'h0000_0001, 32'h0000_0004, 5);
    check("nomdu_execr_aluop", int'(tr[2][6:5]), 2);
    check("nomdu_no_start", cnt_bit(B_MST, 0, 4) + cnt_bit(B_MSEL, 0, 4), 0);
    check("nomdu_aluwb", int'(tr[3][B_RW]), 1);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
